rr_alu_sequencer: RTL and testbench

Hardware control-step sequencer that replaces hand-driven bench stimulus for register-register ALU instructions on the bus datapath. It generates the fetch steps (T0–T2) and the execute steps (T3 onward) as one-hot register strobes. Register count is parametrised and memory-read stall handling is added. Optionally, multiply/divide results are written back into HI/LO. It sits between the IR and the `Datapath` control inputs and is the precursor of the full control unit.

---
 rtl/rr_alu_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_rr_alu_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_alu_sequencer.sv
// Control-step sequencer for register-register ALU instructions: fetch T0-T2 with memory stall, execute T3 onward.
// Define SEQ_HILO_EN to route MUL_OPC/DIV_OPC results into LO (T5) and HI (T6).
module rr_alu_sequencer #(
  parameter int         NUM_REGS = 16,
  parameter logic [4:0] MUL_OPC  = 5'b01111,
  parameter logic [4:0] DIV_OPC  = 5'b10000
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  output logic                pc_out,
  output logic                pc_increment,
  output logic                mar_in,
  output logic                pc_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                zlow_in,
  output logic                zhigh_in,
  output logic                zlow_out,
  output logic                zhigh_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [4:0]          op_code,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [3:0]          step
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8,
    S_DONE = 4'd9
  } state_e;

  localparam logic [4:0] NREG5 = 5'(NUM_REGS);

  state_e     state_q, state_d;
  logic       err_q, err_d;
  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       hilo_op;
  logic       idx_bad;

  assign opc = ir[31:27];
  assign ra  = ir[26:23];
  assign rb  = ir[22:19];
  assign rc  = ir[18:15];

`ifdef SEQ_HILO_EN
  assign hilo_op = (opc == MUL_OPC) || (opc == DIV_OPC);
  logic [14:0] unused_ir;
  assign unused_ir = ir[14:0];
`else
  assign hilo_op = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{MUL_OPC, DIV_OPC, ir[14:0]};
`endif

  function automatic logic idx_ok(input logic [3:0] idx);
    return {1'b0, idx} < NREG5;
  endfunction

  // Out-of-range indices match no bit, so the strobe vector stays all-zero.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i] = (idx == 4'(i));
    return v;
  endfunction

  assign idx_bad = hilo_op ? (!idx_ok(ra) || !idx_ok(rb))
                           : (!idx_ok(ra) || !idx_ok(rb) || !idx_ok(rc));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_T0;
          err_d   = 1'b0;
        end
      end
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1W;
      S_T1W:  if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        state_d = S_T4;
        if (idx_bad) err_d = 1'b1;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = hilo_op ? S_T6 : S_DONE;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Moore decode: every strobe follows the state register (ir is stable from T3).
  always_comb begin
    pc_out       = 1'b0;
    pc_increment = 1'b0;
    mar_in       = 1'b0;
    pc_in        = 1'b0;
    read         = 1'b0;
    mdr_in       = 1'b0;
    mdr_out      = 1'b0;
    ir_in        = 1'b0;
    y_in         = 1'b0;
    zlow_in      = 1'b0;
    zhigh_in     = 1'b0;
    zlow_out     = 1'b0;
    zhigh_out    = 1'b0;
    hi_in        = 1'b0;
    lo_in        = 1'b0;
    reg_in       = '0;
    reg_out      = '0;
    op_code      = 5'd0;
    done         = 1'b0;
    case (state_q)
      S_T0: begin
        pc_out       = 1'b1;
        pc_increment = 1'b1;
        mar_in       = 1'b1;
        zlow_in      = 1'b1;
        zhigh_in     = 1'b1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T1W: begin
        read   = 1'b1;
        mdr_in = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        reg_out = hilo_op ? onehot(ra) : onehot(rb);
        y_in    = 1'b1;
      end
      S_T4: begin
        reg_out  = hilo_op ? onehot(rb) : onehot(rc);
        zlow_in  = 1'b1;
        zhigh_in = 1'b1;
        op_code  = opc;
      end
      S_T5: begin
        zlow_out = 1'b1;
        if (hilo_op) lo_in = 1'b1;
        else         reg_in = onehot(ra);
      end
`ifdef SEQ_HILO_EN
      S_T6: begin
        zhigh_out = 1'b1;
        hi_in     = 1'b1;
      end
`endif
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign err  = err_q;
  assign step = state_q;

endmodule

// File: tb/tb_rr_alu_sequencer.sv
// Scoreboard bench for rr_alu_sequencer: expected per-cycle traces queued at issue, popped by a negedge monitor.
module tb_rr_alu_sequencer;

  typedef struct packed {
    logic [3:0]  step;
    logic [14:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  opc;
    logic        done;
    logic        err;
  } rec_t;

  // strobe order: pc_out pc_increment mar_in pc_in read mdr_in mdr_out ir_in y_in zlow_in zhigh_in zlow_out zhigh_out hi_in lo_in
  localparam logic [14:0] ST_T0  = 15'b111000000110000;
  localparam logic [14:0] ST_T1  = 15'b000111000001000;
  localparam logic [14:0] ST_T1W = 15'b000011000000000;
  localparam logic [14:0] ST_T2  = 15'b000000110000000;
  localparam logic [14:0] ST_T3  = 15'b000000001000000;
  localparam logic [14:0] ST_T4  = 15'b000000000110000;
  localparam logic [14:0] ST_T5N = 15'b000000000001000;
  localparam logic [14:0] ST_T5H = 15'b000000000001001;
  localparam logic [14:0] ST_T6  = 15'b000000000000110;

  logic clk, clr, start16, start8, mem_ready;
  logic [31:0] ir;

  logic [14:0] strb16, strb8;
  logic [15:0] rin16, rout16;
  logic [7:0]  rin8, rout8;
  logic [4:0]  opc16, opc8;
  logic        busy16, done16, err16, busy8, done8, err8;
  logic [3:0]  step16, step8;
  rec_t        obs16, obs8;

  int total = 0;
  int bad = 0;
  rec_t q16[$];
  rec_t q8[$];

  rr_alu_sequencer #(.NUM_REGS(16)) dut16 (
    .clk(clk), .clr(clr), .start(start16), .mem_ready(mem_ready), .ir(ir),
    .pc_out(strb16[14]), .pc_increment(strb16[13]), .mar_in(strb16[12]), .pc_in(strb16[11]),
    .read(strb16[10]), .mdr_in(strb16[9]), .mdr_out(strb16[8]), .ir_in(strb16[7]), .y_in(strb16[6]),
    .zlow_in(strb16[5]), .zhigh_in(strb16[4]), .zlow_out(strb16[3]), .zhigh_out(strb16[2]),
    .hi_in(strb16[1]), .lo_in(strb16[0]),
    .reg_in(rin16), .reg_out(rout16), .op_code(opc16),
    .busy(busy16), .done(done16), .err(err16), .step(step16)
  );

  rr_alu_sequencer #(.NUM_REGS(8)) dut8 (
    .clk(clk), .clr(clr), .start(start8), .mem_ready(mem_ready), .ir(ir),
    .pc_out(strb8[14]), .pc_increment(strb8[13]), .mar_in(strb8[12]), .pc_in(strb8[11]),
    .read(strb8[10]), .mdr_in(strb8[9]), .mdr_out(strb8[8]), .ir_in(strb8[7]), .y_in(strb8[6]),
    .zlow_in(strb8[5]), .zhigh_in(strb8[4]), .zlow_out(strb8[3]), .zhigh_out(strb8[2]),
    .hi_in(strb8[1]), .lo_in(strb8[0]),
    .reg_in(rin8), .reg_out(rout8), .op_code(opc8),
    .busy(busy8), .done(done8), .err(err8), .step(step8)
  );

  assign obs16 = {step16, strb16, rin16, rout16, opc16, done16, err16};
  assign obs8  = {step8, strb8, 8'h00, rin8, 8'h00, rout8, opc8, done8, err8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    rec_t e;
    if (busy16) begin
      total++;
      if (q16.size() == 0) begin
        bad++;
        $display("FAIL trace16 unexpected busy act=%h exp=none", obs16);
      end else begin
        e = q16.pop_front();
        if (obs16 !== e) begin
          bad++;
          $display("FAIL trace16 step act=%h exp=%h", obs16, e);
        end
      end
    end
    if (busy8) begin
      total++;
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL trace8 unexpected busy act=%h exp=none", obs8);
      end else begin
        e = q8.pop_front();
        if (obs8 !== e) begin
          bad++;
          $display("FAIL trace8 step act=%h exp=%h", obs8, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [3:0] s, input logic [14:0] st, input logic [15:0] ri,
                      input logic [15:0] ro, input logic [4:0] oc, input logic dn, input logic er);
    rec_t r;
    r = {s, st, ri, ro, oc, dn, er};
    if (sel) q8.push_back(r);
    else     q16.push_back(r);
  endtask

  task automatic push_fetch(input bit sel, input int stalls);
    push(sel, 4'd1, ST_T0, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    push(sel, 4'd2, ST_T1, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < stalls; i++) push(sel, 4'd3, ST_T1W, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    push(sel, 4'd4, ST_T2, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic push_normal(input bit sel, input int stalls, input logic [15:0] t3o, input logic [15:0] t4o,
                             input logic [15:0] t5i, input logic [4:0] oc, input logic e4);
    push_fetch(sel, stalls);
    push(sel, 4'd5, ST_T3,  16'h0, t3o,   5'd0, 1'b0, 1'b0);
    push(sel, 4'd6, ST_T4,  16'h0, t4o,   oc,   1'b0, e4);
    push(sel, 4'd7, ST_T5N, t5i,   16'h0, 5'd0, 1'b0, e4);
    push(sel, 4'd9, 15'd0,  16'h0, 16'h0, 5'd0, 1'b1, e4);
  endtask

  task automatic push_hilo(input int stalls, input logic [15:0] t3o, input logic [15:0] t4o, input logic [4:0] oc);
    push_fetch(1'b0, stalls);
    push(1'b0, 4'd5, ST_T3,  16'h0, t3o,   5'd0, 1'b0, 1'b0);
    push(1'b0, 4'd6, ST_T4,  16'h0, t4o,   oc,   1'b0, 1'b0);
    push(1'b0, 4'd7, ST_T5H, 16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    push(1'b0, 4'd8, ST_T6,  16'h0, 16'h0, 5'd0, 1'b0, 1'b0);
    push(1'b0, 4'd9, 15'd0,  16'h0, 16'h0, 5'd0, 1'b1, 1'b0);
  endtask

  // Issue a start pulse, drive mem_ready low for `stalls` cycles from T1, and check the done cycle.
  task automatic run_instr(input string name, input bit sel, input logic [31:0] irv, input int stalls,
                           input int exp_cyc);
    int cyc;
    @(negedge clk);
    ir = irv;
    mem_ready = 1'b1;
    if (sel) start8 = 1'b1;
    else     start16 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    start16 = 1'b0;
    cyc = 1;
    while (1) begin
      mem_ready = (cyc >= stalls + 2);
      @(negedge clk);
      if (sel ? done8 : done16) break;
      if (cyc >= 40) begin
        $display("FAIL %s timeout waiting for done act=%0d exp=%0d", name, cyc, exp_cyc);
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_ready = 1'b1;
    check({name, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    clr = 1'b1; start16 = 1'b0; start8 = 1'b0; mem_ready = 1'b1; ir = 32'h0;
    #3;
    check("reset_outputs16", 64'(obs16), 64'h0);
    check("reset_outputs8", 64'(obs8), 64'h0);
    check("reset_busy", 64'({busy16, busy8}), 64'h0);
    @(negedge clk); @(negedge clk);
    clr = 1'b0;

    push_normal(1'b0, 0, 16'h0008, 16'h0080, 16'h0010, 5'b01011, 1'b0);
    run_instr("shl", 1'b0, 32'h5A1B8000, 0, 7);

    push_normal(1'b0, 3, 16'h0008, 16'h0080, 16'h0010, 5'b01011, 1'b0);
    run_instr("stall3", 1'b0, 32'h5A1B8000, 3, 10);

    push_normal(1'b0, 1, 16'h0008, 16'h0080, 16'h0010, 5'b01011, 1'b0);
    run_instr("stall1", 1'b0, 32'h5A1B8000, 1, 8);

`ifdef SEQ_HILO_EN
    push_hilo(0, 16'h0004, 16'h0040, 5'b01111);
    run_instr("mul", 1'b0, 32'h79300000, 0, 8);
    push_hilo(0, 16'h0002, 16'h0020, 5'b10000);
    run_instr("div", 1'b0, 32'h80A80000, 0, 8);
`else
    push_normal(1'b0, 0, 16'h0040, 16'h0001, 16'h0004, 5'b01111, 1'b0);
    run_instr("mul", 1'b0, 32'h79300000, 0, 7);
    push_normal(1'b0, 0, 16'h0020, 16'h0001, 16'h0002, 5'b10000, 1'b0);
    run_instr("div", 1'b0, 32'h80A80000, 0, 7);
`endif

    push_normal(1'b1, 0, 16'h0008, 16'h0000, 16'h0010, 5'b01011, 1'b1);
    run_instr("oor_rc", 1'b1, 32'h5A1C8000, 0, 7);
    check("oor_err_sticky", 64'(err8), 64'h1);
    push_normal(1'b1, 0, 16'h0008, 16'h0080, 16'h0010, 5'b01011, 1'b0);
    run_instr("oor_clear", 1'b1, 32'h5A1B8000, 0, 7);
    check("oor_err_cleared", 64'(err8), 64'h0);

    // clr during T4: outputs must drop without waiting for a clock edge
    push_normal(1'b0, 0, 16'h0008, 16'h0080, 16'h0010, 5'b01011, 1'b0);
    @(negedge clk);
    ir = 32'h5A1B8000;
    start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    k = 0;
    while (step16 != 4'd6 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("clr_reached_t4", 64'(step16), 64'h6);
    #2 clr = 1'b1;
    #1;
    check("clr_outputs", 64'(obs16), 64'h0);
    check("clr_busy", 64'(busy16), 64'h0);
    q16.delete();
    #1 clr = 1'b0;
    @(posedge clk); #1;

    // start held high: DONE ignores it, IDLE accepts it one cycle later
    push_normal(1'b0, 0, 16'h0008, 16'h0080, 16'h0010, 5'b01011, 1'b0);
    push_normal(1'b0, 0, 16'h0008, 16'h0080, 16'h0010, 5'b01011, 1'b0);
    @(negedge clk);
    ir = 32'h5A1B8000;
    start16 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done16 && k < 40);
    check("hold_first_done", 64'(done16), 64'h1);
    @(negedge clk);
    check("hold_idle_gap", 64'({busy16, step16}), 64'h0);
    @(negedge clk);
    check("hold_restart_t0", 64'(step16), 64'h1);
    start16 = 1'b0;
    k = 0;
    while (!done16 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("hold_second_done", 64'(done16), 64'h1);
    @(negedge clk);
    @(negedge clk);
    check("hold_back_idle", 64'(step16), 64'h0);

    check("queue16_drained", 64'(q16.size()), 64'h0);
    check("queue8_drained", 64'(q8.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
